// File: rtl/sd_write_buffer_if.sv
// sd_write_buffer_if: groups the pixel-request side, the SDRAM write side and
// the status outputs of sd_write_buffer into one bundle.
// Ports: slave = buffer view (accepts pixels, drives SDRAM), master = environment view.
interface sd_write_buffer_if;
    // pixel request side
    logic        in_write;
    logic [27:0] in_address;
    logic [31:0] in_data;
    logic        in_full;
    logic        frame_done;
    // SDRAM write side
    logic        SD_write;
    logic [27:0] SD_address;
    logic [31:0] SD_wdata;
    logic        SD_waitrequest;
    // status
    logic        empty;
    logic        overflow;
    logic        frame_flushed;
    logic [27:0] display_base;

    modport slave (
        input  in_write, in_address, in_data, frame_done, SD_waitrequest,
        output in_full, SD_write, SD_address, SD_wdata,
               empty, overflow, frame_flushed, display_base
    );

    modport master (
        output in_write, in_address, in_data, frame_done, SD_waitrequest,
        input  in_full, SD_write, SD_address, SD_wdata,
               empty, overflow, frame_flushed, display_base
    );
endinterface

// File: rtl/sd_write_buffer.sv
// sd_write_buffer: FIFO of pixel writes (offset + frame base) drained to SDRAM in push order.
// Latency: an entry pushed into an empty, idle buffer appears on SD_write two edges later.
// Backpressure: SD_waitrequest holds the current write; in_full stops pushes, dropped requests set overflow.
// Ports: clk, reset (async active-high), bus (sd_write_buffer_if.slave).
// Build option: SD_DOUBLE_BUFFER_EN enables BASE0/BASE1 ping-pong per frame.
module sd_write_buffer #(
    parameter int          DEPTH = 8,
    parameter logic [27:0] BASE0 = 28'h0000000,
    parameter logic [27:0] BASE1 = 28'h0080000
) (
    input  logic             clk,
    input  logic             reset,
    sd_write_buffer_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    typedef enum logic {S_IDLE = 1'b0, S_WRITE = 1'b1} state_t;

    state_t         r_state, w_state_nxt;
    logic [59:0]    r_mem [DEPTH];          // {address, data}
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [AW-1:0]  w_rd_ptr_p1, w_load_ptr;
    logic [AW:0]    r_count;                // includes the entry currently on the SDRAM bus
    logic           r_head_settled;
    logic           r_sd_write, w_sd_write_nxt;
    logic [27:0]    r_sd_address;
    logic [31:0]    r_sd_wdata;
    logic           w_load, w_pop, w_push, w_full, w_empty;
    logic           r_overflow;
    logic           r_flush_pending, r_frame_flushed;
    logic           w_flush_fire, w_fd_accept;
    logic [27:0]    w_active_base, w_push_addr;

    assign w_full      = (r_count == FULL_CNT);
    assign w_push      = bus.in_write && !w_full;
    assign w_empty     = (r_count == '0) && (r_state == S_IDLE);
    assign w_rd_ptr_p1 = r_rd_ptr + AW'(1);
    assign w_push_addr = bus.in_address + w_active_base;

    // A frame_done arriving while a flush is still outstanding merges into it;
    // one arriving in the very cycle that flush completes starts a new one.
    assign w_flush_fire = r_flush_pending && w_empty;
    assign w_fd_accept  = bus.frame_done && (!r_flush_pending || w_flush_fire);

`ifdef SD_DOUBLE_BUFFER_EN
    logic        r_base_sel;
    logic [27:0] r_flush_base;    // base of the frame awaiting its flush
    logic [27:0] r_display_base;

    assign w_active_base = r_base_sel ? BASE1 : BASE0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base_sel     <= 1'b0;
            r_flush_base   <= BASE0;
            r_display_base <= BASE0;
        end else begin
            if (w_fd_accept) begin
                r_base_sel   <= ~r_base_sel;
                r_flush_base <= w_active_base;
            end
            if (w_flush_fire)
                r_display_base <= r_flush_base;
        end
    end

    assign bus.display_base = r_display_base;
`else
    logic w_unused_base1;
    assign w_unused_base1   = ^BASE1;
    assign w_active_base    = BASE0;
    assign bus.display_base = BASE0;
`endif

    // Storage has no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {w_push_addr, bus.in_data};
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sd_write_nxt = r_sd_write;
        w_load         = 1'b0;
        w_pop          = 1'b0;
        w_load_ptr     = r_rd_ptr;
        case (r_state)
            S_IDLE: begin
                // Launch only once the head has been resident for a full cycle,
                // giving a fixed two-edge push-to-write latency.
                if (r_head_settled && (r_count != '0)) begin
                    w_load         = 1'b1;
                    w_sd_write_nxt = 1'b1;
                    w_state_nxt    = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!bus.SD_waitrequest) begin
                    w_pop = 1'b1;
                    // An entry pushed this same cycle is not yet readable, so
                    // back-to-back continues only if one is already stored.
                    if (r_count > ONE_CNT) begin
                        w_load     = 1'b1;
                        w_load_ptr = w_rd_ptr_p1;
                    end else begin
                        w_sd_write_nxt = 1'b0;
                        w_state_nxt    = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_head_settled  <= 1'b0;
            r_sd_write      <= 1'b0;
            r_sd_address    <= '0;
            r_sd_wdata      <= '0;
            r_overflow      <= 1'b0;
            r_flush_pending <= 1'b0;
            r_frame_flushed <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_sd_write     <= w_sd_write_nxt;
            r_head_settled <= (r_count != '0);

            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= w_rd_ptr_p1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase

            if (w_load) begin
                r_sd_address <= r_mem[w_load_ptr][59:32];
                r_sd_wdata   <= r_mem[w_load_ptr][31:0];
            end

            if (bus.in_write && w_full)
                r_overflow <= 1'b1;

            if (w_fd_accept)
                r_flush_pending <= 1'b1;
            else if (w_flush_fire)
                r_flush_pending <= 1'b0;

            r_frame_flushed <= w_flush_fire;
        end
    end

    assign bus.in_full       = w_full;
    assign bus.SD_write      = r_sd_write;
    assign bus.SD_address    = r_sd_address;
    assign bus.SD_wdata      = r_sd_wdata;
    assign bus.empty         = w_empty;
    assign bus.overflow      = r_overflow;
    assign bus.frame_flushed = r_frame_flushed;
endmodule

// File: tb/tb_sd_write_buffer.sv
// tb_sd_write_buffer: directed scenarios plus random traffic for sd_write_buffer,
// checked against a queue-based reference model of the buffer contents.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units after it.
module tb_sd_write_buffer;
    localparam int          DEPTH = 8;
    localparam logic [27:0] BASE0 = 28'h0000000;
    localparam logic [27:0] BASE1 = 28'h0080000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sd_write_buffer_if bus();

    sd_write_buffer #(.DEPTH(DEPTH), .BASE0(BASE0), .BASE1(BASE1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [59:0] m_q[$];         // accepted, not yet written entries (head may be on the bus)
    logic        m_ovf, m_pend, m_ff, m_sel, m_hold;
    logic [27:0] m_flush_base, m_disp, m_hold_addr;
    logic [31:0] m_hold_data;
    int          n_xfer, n_pulse;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf        = 1'b0;
        m_pend       = 1'b0;
        m_ff         = 1'b0;
        m_sel        = 1'b0;
        m_hold       = 1'b0;
        m_flush_base = BASE0;
        m_disp       = BASE0;
        m_hold_addr  = '0;
        m_hold_data  = '0;
    endtask

    // One clock cycle: apply inputs, check outputs against the model, predict
    // the effect of the coming edge, then advance past it.
    task automatic cycle(input logic w, input logic [27:0] a, input logic [31:0] d,
                         input logic fd, input logic wr);
        logic        full_now, empty_now, fire;
        logic [59:0] e;
        logic [27:0] base, ea;
        bus.in_write       = w;
        bus.in_address     = a;
        bus.in_data        = d;
        bus.frame_done     = fd;
        bus.SD_waitrequest = wr;
        #1;
        full_now  = (m_q.size() == DEPTH);
        empty_now = (m_q.size() == 0);
        chk("in_full", bus.in_full, full_now);
        chk("empty", bus.empty, empty_now);
        chk("overflow", bus.overflow, m_ovf);
        chk("frame_flushed", bus.frame_flushed, m_ff);
        chk("display_base", bus.display_base, m_disp);
        if (bus.frame_flushed) n_pulse++;
        if (m_hold) begin
            chk("hold_write", bus.SD_write, 1'b1);
            chk("hold_addr", bus.SD_address, m_hold_addr);
            chk("hold_data", bus.SD_wdata, m_hold_data);
        end
        if (bus.SD_write && !wr) begin
            if (m_q.size() == 0) begin
                chk("spurious_write", bus.SD_write, 1'b0);
            end else begin
                e = m_q.pop_front();
                chk("sd_address", bus.SD_address, e[59:32]);
                chk("sd_wdata", bus.SD_wdata, e[31:0]);
                n_xfer++;
            end
        end
        m_hold      = bus.SD_write && wr;
        m_hold_addr = bus.SD_address;
        m_hold_data = bus.SD_wdata;
        base = m_sel ? BASE1 : BASE0;
        ea   = a + base;
        if (w && !full_now) m_q.push_back({ea, d});
        if (w && full_now)  m_ovf = 1'b1;
        fire = m_pend && empty_now;
        if (fd && (!m_pend || fire)) begin
            m_pend = 1'b1;
`ifdef SD_DOUBLE_BUFFER_EN
            m_flush_base = base;
            m_sel        = ~m_sel;
`endif
        end else if (fire) begin
            m_pend = 1'b0;
        end
`ifdef SD_DOUBLE_BUFFER_EN
        if (fire) m_disp = m_flush_base;
`endif
        m_ff = fire;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0, p0;
        model_reset();
        n_xfer  = 0;
        n_pulse = 0;
        reset              = 1'b1;
        bus.in_write       = 1'b0;
        bus.in_address     = '0;
        bus.in_data        = '0;
        bus.frame_done     = 1'b0;
        bus.SD_waitrequest = 1'b0;
        #12;
        chk("rst_sd_write", bus.SD_write, 1'b0);
        chk("rst_sd_address", bus.SD_address, 28'h0);
        chk("rst_sd_wdata", bus.SD_wdata, 32'h0);
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_in_full", bus.in_full, 1'b0);
        chk("rst_overflow", bus.overflow, 1'b0);
        chk("rst_frame_flushed", bus.frame_flushed, 1'b0);
        chk("rst_display_base", bus.display_base, BASE0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // single write, fixed latency
        cycle(1'b1, 28'h5, 32'hAABBCCDD, 1'b0, 1'b0);
        chk("lat_edge_k", bus.SD_write, 1'b0);
        idle(1);
        chk("lat_edge_k1", bus.SD_write, 1'b0);
        idle(1);
        chk("lat_edge_k2", bus.SD_write, 1'b1);
        chk("single_addr", bus.SD_address, 28'h0000005);
        chk("single_data", bus.SD_wdata, 32'hAABBCCDD);
        idle(1);
        chk("single_done_write", bus.SD_write, 1'b0);
        chk("single_done_empty", bus.empty, 1'b1);

        // three entries stalled, then back-to-back
        for (int i = 0; i < 3; i++) cycle(1'b1, 28'(16 + i), 32'(32'h100 + i), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_write", bus.SD_write, 1'b1);
            cycle(1'b0, '0, '0, 1'b0, 1'b0);
        end
        chk("b2b_end_write", bus.SD_write, 1'b0);

        // fill beyond DEPTH under stall
        x0 = n_xfer;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 28'(32'h200 + i), $urandom, 1'b0, 1'b1);
            if (i == 7) begin
                chk("full_after_8", bus.in_full, 1'b1);
                chk("ovf_not_yet", bus.overflow, 1'b0);
            end
        end
        chk("ovf_after_10", bus.overflow, 1'b1);
        idle(20);
        chk("full_drain_cnt", n_xfer - x0, 8);

        // frame handling
        p0 = n_pulse;
        cycle(1'b1, 28'h1, 32'h11, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b1, 28'h1, 32'h22, 1'b0, 1'b0);
        idle(10);
        chk("flush_pulse_1", n_pulse - p0, 1);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        idle(5);
        chk("flush_pulse_2", n_pulse - p0, 2);
`ifdef SD_DOUBLE_BUFFER_EN
        chk("display_after_2", bus.display_base, BASE1);
`else
        chk("display_after_2", bus.display_base, BASE0);
`endif

        // reset in the middle of a stalled write with 4 queued
        for (int i = 0; i < 4; i++) cycle(1'b1, 28'(32'h300 + i), $urandom, 1'b0, 1'b1);
        chk("pre_reset_write", bus.SD_write, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset_write", bus.SD_write, 1'b0);
        chk("mid_reset_empty", bus.empty, 1'b1);
        chk("mid_reset_ovf", bus.overflow, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        x0 = n_xfer;
        cycle(1'b1, 28'h123, 32'hCAFE0001, 1'b0, 1'b0);
        idle(10);
        chk("post_reset_writes", n_xfer - x0, 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 99) < 60, 28'($urandom), $urandom,
                  $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 40);
        end
        for (int i = 0; i < 200 && m_q.size() != 0; i++) idle(1);
        idle(2);
        chk("final_empty", bus.empty, 1'b1);
        chk("final_write", bus.SD_write, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sd_write_buffer.md
SD_WRITE_BUFFER -- requirements
Module: sd_write_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries (power of two, >=2).
REQ-002 Parameter BASE0, default 28'h0000000, frame buffer 0 base address.
REQ-003 Parameter BASE1, default 28'h0080000, frame buffer 1 base address.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_write  input  1  pixel write request from output controller.
REQ-007 in_address  input  28  pixel offset within frame.
REQ-008 in_data  input  32  pixel word.
REQ-009 in_full  output  1  FIFO full; requests not accepted.
REQ-010 frame_done  input  1  single-cycle end-of-frame marker.
REQ-011 SD_write  output  1  SDRAM write request.
REQ-012 SD_address  output  28  SDRAM write address.
REQ-013 SD_wdata  output  32  SDRAM write data.
REQ-014 SD_waitrequest  input  1  SDRAM stall.
REQ-015 empty  output  1  FIFO empty and no write in flight.
REQ-016 overflow  output  1  sticky: request dropped while full.
REQ-017 frame_flushed  output  1  single-cycle pulse: frame fully written.
REQ-018 display_base  output  28  base of last completed frame.

Function
REQ-019 Push when in_write=1 and in_full=0; entry = {in_address + active base (28-bit wrap), in_data}.
REQ-020 in_full = (count == DEPTH); pop in same cycle does not free a slot for a push.
REQ-021 in_write=1 while in_full=1: request dropped, overflow set to 1 next edge.
REQ-022 FSM states IDLE, WRITE.
REQ-023 IDLE: FIFO non-empty -> load head into SD_address/SD_wdata, SD_write=1, go WRITE.
REQ-024 Entry pushed at edge k into empty FIFO in IDLE: SD_write high after edge k+2.
REQ-025 WRITE: SD_write, SD_address, SD_wdata held stable while SD_waitrequest=1.
REQ-026 WRITE with SD_waitrequest=0: transfer done, head popped; FIFO still non-empty -> next entry loaded, stay WRITE (back-to-back, no idle cycle); else SD_write=0, go IDLE.
REQ-027 Writes issued in strict push order; no entry lost or duplicated.
REQ-028 empty = 1 only when count=0 and state=IDLE.
REQ-029 frame_done sets flush_pending; repeat frame_done while pending merges (one pulse only).
REQ-030 flush_pending=1 and empty=1: frame_flushed=1 one cycle, flush_pending cleared.
REQ-031 Push and frame_done same cycle: push uses base active before frame_done.
REQ-032 count width clog2(DEPTH)+1; read/write pointers wrap modulo DEPTH.

Reset
REQ-033 reset=1 forces immediately: state IDLE, count 0, pointers 0, SD_write 0, SD_address 0, SD_wdata 0, overflow 0, flush_pending 0, frame_flushed 0, base select 0, display_base BASE0.
REQ-034 Reset during WRITE abandons the in-flight write and all buffered entries.
REQ-035 After release, first push accepted on first rising edge with reset=0.

Configuration
REQ-036 Macro SD_DOUBLE_BUFFER_EN.
REQ-037 Defined: active base toggles BASE0/BASE1 on each accepted frame_done; display_base takes base of flushed frame on frame_flushed pulse.
REQ-038 Undefined: active base always BASE0; display_base constant BASE0; all other behaviour identical.

Verification
REQ-039 Reset, push addr 5 data 32'hAABBCCDD, waitrequest=0 -> SD_write high one cycle, SD_address 28'h0000005, SD_wdata 32'hAABBCCDD, then empty=1.
REQ-040 Push 3 entries, waitrequest=1 for 4 cycles -> SD outputs stable 4 cycles, then 3 back-to-back writes in order, SD_write low after.
REQ-041 DEPTH=8, waitrequest=1, push 10 -> in_full=1 after 8th, overflow=1, exactly 8 writes after release.
REQ-042 EN defined: push addr 1, frame_done, push addr 1 -> addresses 28'h0000001 then 28'h0080001; frame_flushed once; display_base 28'h0080000 after second frame_done flushes.
REQ-043 EN undefined: same stimulus -> both addresses 28'h0000001; display_base stays 28'h0000000.
REQ-044 Reset asserted mid-WRITE with 4 entries queued -> SD_write 0 immediately, empty=1, no further writes after release.
